// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode codes and status-flag bit positions.
// Imported by the result buffer and any later stage that decodes flags.
package alu_pkg;

  localparam logic [3:0] OP_MUL  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_NAND = 4'd14;
  localparam logic [3:0] OP_BAD  = 4'd15;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_NEG   = 2;
  localparam int FLG_BAD   = 3;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Status flags for one ALU result, derived from its opcode and value.
// Purely combinational so later stages can reuse it.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 4
) (
  input  logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] fout,
  output flags_t            flags
);

  logic is_mul;
  logic has_carry;

  always_comb begin
    is_mul    = (sel == OP_MUL);
    has_carry = (sel == OP_ADD) || (sel == OP_SUB);
    flags            = '0;
    flags[FLG_ZERO]  = (fout == '0);
    flags[FLG_CARRY] = has_carry ? fout[8] : 1'b0;
    // multiply yields a full 16-bit product, others an 8-bit result
    flags[FLG_NEG]   = is_mul ? fout[15] : fout[7];
    flags[FLG_BAD]   = (sel == OP_BAD);
  end

endmodule

// File: rtl/alu_result_buffer.sv
// Registers ALU results with their flags in a small FIFO and hands
// them to a consumer over valid/ready.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int SEL_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [DATA_W-1:0]        in_fout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         out_sel,
  output logic [DATA_W-1:0]        out_data,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_op
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [SEL_W-1:0]  sel_q  [DEPTH];
  logic [SEL_W-1:0]  sel_d  [DEPTH];
  flags_t            flg_q  [DEPTH];
  flags_t            flg_d  [DEPTH];

  flags_t in_flags;
  logic   push;
  logic   pop;

  alu_flag_gen #(
    .DATA_W(DATA_W),
    .SEL_W (SEL_W)
  ) u_flag_gen (
    .sel  (in_sel),
    .fout (in_fout),
    .flags(in_flags)
  );

  // ready comes from registered occupancy only, so a full
  // buffer refuses a push even when the head is popped
  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    err_d    = err_q;
    data_d   = data_q;
    sel_d    = sel_q;
    flg_d    = flg_q;
    if (push) begin
      data_d[wr_ptr_q] = in_fout;
      sel_d[wr_ptr_q]  = in_sel;
      flg_d[wr_ptr_q]  = in_flags;
      wr_ptr_d         = wr_ptr_q + PW'(1);
      err_d            = err_q | in_flags[FLG_BAD];
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      err_q    <= err_d;
    end
  end

  // storage survives reset; emptiness is carried by level_q
  always_ff @(posedge clk) begin
    data_q <= data_d;
    sel_q  <= sel_d;
    flg_q  <= flg_d;
  end

  always_comb begin
    out_data  = '0;
    out_sel   = '0;
    out_flags = '0;
    if (out_valid) begin
      out_data  = data_q[rd_ptr_q];
      out_sel   = sel_q[rd_ptr_q];
      out_flags = flg_q[rd_ptr_q];
    end
  end

  assign level  = level_q;
  assign err_op = err_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Bench for alu_result_buffer: directed table, corner sequences and
// random traffic checked against a queue-based reference model.
module tb_alu_result_buffer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_sel;
  logic [15:0] in_fout;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_sel;
  logic [15:0] out_data;
  logic [3:0]  out_flags;
  logic [2:0]  level;
  logic        err_op;

  alu_result_buffer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_fout  (in_fout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sel  (out_sel),
    .out_data (out_data),
    .out_flags(out_flags),
    .level    (level),
    .err_op   (err_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] data;
    logic [3:0]  flg;
  } ent_t;

  typedef struct {
    logic        iv;
    logic [3:0]  sel;
    logic [15:0] fout;
    logic        ordy;
    int          exp_level;
    logic        exp_ready;
    logic [15:0] exp_data;
    logic [3:0]  exp_flags;
  } vec_t;

  ent_t mq[$];
  bit   merr;
  int   errors = 0;
  int   checks = 0;

  localparam int CAP = 4;

  function automatic logic [3:0] ref_flags(logic [3:0] s, logic [15:0] f);
    logic bad, neg, cy, zr;
    bad = (s == 4'd15);
    neg = (s == 4'd0) ? f[15] : f[7];
    cy  = (s == 4'd1 || s == 4'd2) ? f[8] : 1'b0;
    zr  = (f == 16'd0);
    return {bad, neg, cy, zr};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("level", 32'(level), 32'(mq.size()));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(mq.size() != CAP));
    chk("err_op", 32'(err_op), 32'(merr));
    if (mq.size() != 0) begin
      chk("out_data", 32'(out_data), 32'(mq[0].data));
      chk("out_sel", 32'(out_sel), 32'(mq[0].sel));
      chk("out_flags", 32'(out_flags), 32'(mq[0].flg));
    end
  endtask

  task automatic cycle(input logic iv, input logic [3:0] s,
                       input logic [15:0] f, input logic ordy);
    bit   mpush, mpop;
    ent_t e;
    in_valid  = iv;
    in_sel    = s;
    in_fout   = f;
    out_ready = ordy;
    mpush = iv && (mq.size() < CAP);
    mpop  = ordy && (mq.size() > 0);
    @(posedge clk);
    #1;
    if (mpop) e = mq.pop_front();
    if (mpush) begin
      e.sel  = s;
      e.data = f;
      e.flg  = ref_flags(s, f);
      mq.push_back(e);
      if (s == 4'd15) merr = 1'b1;
    end
    check_model();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete();
    merr = 1'b0;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst level", 32'(level), 32'd0);
    chk("rst err_op", 32'(err_op), 32'd0);
    chk("rst out_data", 32'(out_data), 32'd0);
    chk("rst out_flags", 32'(out_flags), 32'd0);
  endtask

  vec_t tbl[11];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_fout   = '0;
    out_ready = 1'b0;
    merr      = 1'b0;

    tbl[0]  = '{1, 4'd1,  16'h0100, 1, 1, 1, 16'h0100, 4'b0010};
    tbl[1]  = '{0, 4'd0,  16'h0000, 1, 0, 1, 16'h0000, 4'b0000};
    tbl[2]  = '{1, 4'd0,  16'h8000, 0, 1, 1, 16'h8000, 4'b0100};
    tbl[3]  = '{1, 4'd2,  16'h0180, 0, 2, 1, 16'h8000, 4'b0100};
    tbl[4]  = '{1, 4'd3,  16'h0000, 0, 3, 1, 16'h8000, 4'b0100};
    tbl[5]  = '{1, 4'd14, 16'h00FF, 0, 4, 0, 16'h8000, 4'b0100};
    tbl[6]  = '{1, 4'd5,  16'h1234, 0, 4, 0, 16'h8000, 4'b0100};
    tbl[7]  = '{0, 4'd0,  16'h0000, 1, 3, 1, 16'h0180, 4'b0110};
    tbl[8]  = '{0, 4'd0,  16'h0000, 1, 2, 1, 16'h0000, 4'b0001};
    tbl[9]  = '{0, 4'd0,  16'h0000, 1, 1, 1, 16'h00FF, 4'b0100};
    tbl[10] = '{0, 4'd0,  16'h0000, 1, 0, 1, 16'h0000, 4'b0000};

    do_reset();

    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].iv, tbl[i].sel, tbl[i].fout, tbl[i].ordy);
      chk($sformatf("tbl%0d level", i), 32'(level), 32'(tbl[i].exp_level));
      chk($sformatf("tbl%0d in_ready", i), 32'(in_ready),
          32'(tbl[i].exp_ready));
      if (tbl[i].exp_level != 0) begin
        chk($sformatf("tbl%0d data", i), 32'(out_data), 32'(tbl[i].exp_data));
        chk($sformatf("tbl%0d flags", i), 32'(out_flags),
            32'(tbl[i].exp_flags));
      end
    end

    // full with simultaneous pop: push refused that cycle, taken next
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 4'd4, 16'(16'h0A00 + i), 0);
    cycle(1, 4'd4, 16'h0B0B, 1);
    chk("fullpop level", 32'(level), 32'd3);
    chk("fullpop head", 32'(out_data), 32'h0A01);
    cycle(1, 4'd4, 16'h0B0B, 0);
    chk("fullpop retry level", 32'(level), 32'd4);
    for (int i = 0; i < 4; i++) cycle(0, 4'd0, 16'h0, 1);

    // steady push+pop at level 2 across several pointer wraps
    do_reset();
    cycle(1, 4'd6, 16'h1000, 0);
    cycle(1, 4'd6, 16'h1001, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 4'd7, 16'(16'h2000 + i), 1);
      chk("pp level", 32'(level), 32'd2);
    end
    chk("pp head", 32'(out_data), 32'h2008);

    // bad opcode stays sticky until reset
    do_reset();
    cycle(1, 4'd15, 16'h0000, 1);
    chk("bad flags", 32'(out_flags), 32'b1001);
    chk("bad err_op", 32'(err_op), 32'd1);
    cycle(1, 4'd1, 16'h0055, 1);
    cycle(1, 4'd2, 16'h0155, 1);
    cycle(0, 4'd0, 16'h0000, 1);
    chk("bad sticky", 32'(err_op), 32'd1);

    // reset in the middle of traffic
    cycle(1, 4'd3, 16'h3333, 0);
    cycle(1, 4'd3, 16'h4444, 0);
    cycle(1, 4'd3, 16'h5555, 0);
    chk("mid level", 32'(level), 32'd3);
    do_reset();
    cycle(1, 4'd1, 16'h00AA, 0);
    chk("post rst level", 32'(level), 32'd1);
    chk("post rst data", 32'(out_data), 32'h00AA);
    chk("post rst flags", 32'(out_flags), 32'b0100);

    // random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  s;
      logic [15:0] f;
      s = 4'($urandom_range(0, 15));
      f = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      cycle(1'($urandom_range(0, 1)), s, f,
            ($urandom_range(0, 3) != 0));
      if (i == 200) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
